// File: rtl/freq_meter_if.sv
// Control/result bundle for freq_meter: start/continuous requests in, count/strobe/status out.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start_i;
  logic             cont_i;
  logic [CNT_W-1:0] count_o;
  logic             valid_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (output start_i, cont_i, input count_o, valid_o, ovf_o, busy_o);
  modport slave  (input start_i, cont_i, output count_o, valid_o, ovf_o, busy_o);
endinterface

// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts sig_i rises over GATE_CYCLES clk_i cycles and strobes the result.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sig_i,
  freq_meter_if.slave  bus
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]       count_q;
  logic                   valid_q;
  logic                   ovf_q;
  logic                   busy_q;
  logic                   rise_c;

  // Synchronizer and history run in every state so a window never opens on a stale edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Saturating edge count and window counter for the current GATE cycle.
  always_comb begin
    gate_cnt_d = gate_cnt_q + GATE_W'(1);
    edge_cnt_d = edge_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    if (rise_c) begin
      if (edge_cnt_q != CNT_MAX) edge_cnt_d = edge_cnt_q + CNT_W'(1);
      else                       ovf_acc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_acc_q  <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i || bus.cont_i) begin
            state_q    <= ST_GATE;
            busy_q     <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
          end
        end
        ST_GATE: begin
          gate_cnt_q <= gate_cnt_d;
          edge_cnt_q <= edge_cnt_d;
          ovf_acc_q  <= ovf_acc_d;
          // Last window cycle: its own rise is folded into the published result.
          if (gate_cnt_q == GATE_LAST) begin
            state_q <= ST_DONE;
            count_q <= edge_cnt_d;
            ovf_q   <= ovf_acc_d;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.cont_i) begin
            state_q    <= ST_GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count_o = count_q;
  assign bus.valid_o = valid_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit meter and a 3-bit (saturating) meter share one sig_i.
module tb_freq_meter;

  logic clk;
  logic rst_n;
  logic sig;
  int   sig_period;
  logic sig_level;
  int   vectors;
  int   miscompares;

  freq_meter_if #(.CNT_W(16)) ifa ();
  freq_meter_if #(.CNT_W(3))  ifb ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) u_a (
    .clk_i(clk), .rst_i(rst_n), .sig_i(sig), .bus(ifa)
  );
  freq_meter #(.GATE_CYCLES(100), .CNT_W(3), .SYNC_STAGES(2)) u_b (
    .clk_i(clk), .rst_i(rst_n), .sig_i(sig), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square wave with an integer period in clk cycles; period 0 means a static level.
  initial begin
    int phase;
    phase = 0;
    sig   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_period == 0) begin
        sig = sig_level;
      end else begin
        phase = (phase + 1) % sig_period;
        sig   = (phase < sig_period / 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit sel_b, input int bound, output int cycles, output bit found);
    found  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (sel_b ? ifb.valid_o : ifa.valid_o) begin
        cycles = i;
        found  = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sig_period = 4;
    repeat (6) tick();
    vectors += 8;
    if (ifa.count_o !== 16'd0) begin miscompares++; $display("FAIL reset_a_count got %0d want 0", ifa.count_o); end
    if (ifa.valid_o !== 1'b0)  begin miscompares++; $display("FAIL reset_a_valid got %b want 0", ifa.valid_o); end
    if (ifa.ovf_o !== 1'b0)    begin miscompares++; $display("FAIL reset_a_ovf got %b want 0", ifa.ovf_o); end
    if (ifa.busy_o !== 1'b0)   begin miscompares++; $display("FAIL reset_a_busy got %b want 0", ifa.busy_o); end
    if (ifb.count_o !== 3'd0)  begin miscompares++; $display("FAIL reset_b_count got %0d want 0", ifb.count_o); end
    if (ifb.valid_o !== 1'b0)  begin miscompares++; $display("FAIL reset_b_valid got %b want 0", ifb.valid_o); end
    if (ifb.ovf_o !== 1'b0)    begin miscompares++; $display("FAIL reset_b_ovf got %b want 0", ifb.ovf_o); end
    if (ifb.busy_o !== 1'b0)   begin miscompares++; $display("FAIL reset_b_busy got %b want 0", ifb.busy_o); end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_single_shot();
    int valid_seen;
    sig_period = 10;
    repeat (10) tick();
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    valid_seen = 0;
    for (int n = 1; n <= 102; n++) begin
      vectors += 2;
      if (ifa.busy_o !== (n <= 101)) begin
        miscompares++; $display("FAIL single_busy cycle %0d got %b want %b", n, ifa.busy_o, (n <= 101));
      end
      if (ifa.valid_o !== (n == 101)) begin
        miscompares++; $display("FAIL single_valid cycle %0d got %b want %b", n, ifa.valid_o, (n == 101));
      end
      if (n == 101) begin
        vectors += 2;
        if (ifa.count_o !== 16'd10) begin miscompares++; $display("FAIL single_count got %0d want 10", ifa.count_o); end
        if (ifa.ovf_o !== 1'b0)     begin miscompares++; $display("FAIL single_ovf got %b want 0", ifa.ovf_o); end
      end
      tick();
    end
    repeat (20) tick();
    vectors += 2;
    if (ifa.count_o !== 16'd10) begin miscompares++; $display("FAIL single_hold_count got %0d want 10", ifa.count_o); end
    if (ifa.busy_o !== 1'b0)    begin miscompares++; $display("FAIL single_idle_busy got %b want 0", ifa.busy_o); end
  endtask

  task automatic test_continuous();
    int cyc;
    bit found;
    sig_period = 5;
    repeat (10) tick();
    ifa.cont_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, 200, cyc, found);
      vectors += 3;
      if (!found || cyc != 101) begin miscompares++; $display("FAIL cont_period win %0d got %0d want 101 (found=%b)", k, cyc, found); end
      if (ifa.count_o !== 16'd20) begin miscompares++; $display("FAIL cont_count win %0d got %0d want 20", k, ifa.count_o); end
      if (ifa.ovf_o !== 1'b0)     begin miscompares++; $display("FAIL cont_ovf win %0d got %b want 0", k, ifa.ovf_o); end
    end
    repeat (50) tick();
    ifa.cont_i = 1'b0;
    wait_valid(1'b0, 200, cyc, found);
    vectors += 2;
    if (!found || cyc != 51) begin miscompares++; $display("FAIL cont_drop_period got %0d want 51 (found=%b)", cyc, found); end
    if (ifa.count_o !== 16'd20) begin miscompares++; $display("FAIL cont_drop_count got %0d want 20", ifa.count_o); end
    tick();
    vectors += 2;
    if (ifa.busy_o !== 1'b0)  begin miscompares++; $display("FAIL cont_drop_busy got %b want 0", ifa.busy_o); end
    if (ifa.valid_o !== 1'b0) begin miscompares++; $display("FAIL cont_drop_valid got %b want 0", ifa.valid_o); end
  endtask

  task automatic test_overflow();
    int cyc;
    bit found;
    sig_period = 4;
    repeat (10) tick();
    ifb.start_i = 1'b1;
    tick();
    ifb.start_i = 1'b0;
    wait_valid(1'b1, 200, cyc, found);
    vectors += 3;
    if (!found || cyc != 100) begin miscompares++; $display("FAIL ovf_latency got %0d want 100 (found=%b)", cyc, found); end
    if (ifb.count_o !== 3'd7) begin miscompares++; $display("FAIL ovf_count got %0d want 7", ifb.count_o); end
    if (ifb.ovf_o !== 1'b1)   begin miscompares++; $display("FAIL ovf_flag got %b want 1", ifb.ovf_o); end
    sig_period = 20;
    repeat (10) tick();
    ifb.start_i = 1'b1;
    tick();
    ifb.start_i = 1'b0;
    wait_valid(1'b1, 200, cyc, found);
    vectors += 3;
    if (!found)               begin miscompares++; $display("FAIL ovf2_timeout got none want valid"); end
    if (ifb.count_o !== 3'd5) begin miscompares++; $display("FAIL ovf2_count got %0d want 5", ifb.count_o); end
    if (ifb.ovf_o !== 1'b0)   begin miscompares++; $display("FAIL ovf2_flag got %b want 0", ifb.ovf_o); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    int valid_seen;
    sig_period = 10;
    repeat (10) tick();
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    repeat (39) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (ifa.count_o !== 16'd0) begin miscompares++; $display("FAIL mid_async_count got %0d want 0", ifa.count_o); end
    if (ifa.busy_o !== 1'b0)   begin miscompares++; $display("FAIL mid_async_busy got %b want 0", ifa.busy_o); end
    if (ifb.count_o !== 3'd0)  begin miscompares++; $display("FAIL mid_async_b_count got %0d want 0", ifb.count_o); end
    repeat (2) tick();
    rst_n = 1'b1;
    valid_seen = 0;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (ifa.valid_o) valid_seen++;
    end
    vectors += 2;
    if (valid_seen != 0)       begin miscompares++; $display("FAIL mid_no_valid got %0d strobes want 0", valid_seen); end
    if (ifa.count_o !== 16'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", ifa.count_o); end
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    wait_valid(1'b0, 200, cyc, found);
    vectors += 2;
    if (!found || cyc != 100)   begin miscompares++; $display("FAIL mid_restart_latency got %0d want 100 (found=%b)", cyc, found); end
    if (ifa.count_o !== 16'd10) begin miscompares++; $display("FAIL mid_restart_count got %0d want 10", ifa.count_o); end
  endtask

  task automatic test_ignore_static();
    int valid_seen;
    int valid_cycle;
    sig_period = 0;
    sig_level  = 1'b1;
    repeat (10) tick();
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    valid_seen  = 0;
    valid_cycle = 0;
    for (int n = 1; n <= 250; n++) begin
      ifa.start_i = (n == 50);
      if (ifa.valid_o) begin
        valid_seen++;
        valid_cycle = n;
        vectors++;
        if (ifa.count_o !== 16'd0) begin miscompares++; $display("FAIL ignore_count got %0d want 0", ifa.count_o); end
      end
      tick();
    end
    ifa.start_i = 1'b0;
    vectors += 3;
    if (valid_seen != 1)     begin miscompares++; $display("FAIL ignore_strobes got %0d want 1", valid_seen); end
    if (valid_cycle != 101)  begin miscompares++; $display("FAIL ignore_valid_cycle got %0d want 101", valid_cycle); end
    if (ifa.busy_o !== 1'b0) begin miscompares++; $display("FAIL ignore_busy got %b want 0", ifa.busy_o); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sig_period  = 0;
    sig_level   = 1'b0;
    rst_n       = 1'b0;
    ifa.start_i = 1'b0;
    ifa.cont_i  = 1'b0;
    ifb.start_i = 1'b0;
    ifb.cont_i  = 1'b0;
    test_reset();
    test_single_shot();
    test_continuous();
    test_overflow();
    test_reset_mid();
    test_ignore_static();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter, placed directly downstream of the frequency divider. It samples the divided clock (or any slow asynchronous square wave) on `sig_i` and counts its rising edges over a fixed window of `GATE_CYCLES` reference-clock cycles. It then publishes the count with a one-cycle valid strobe, either once per start request or continuously. The software or self-check logic that verifies divider ratios consumes `count_o`.

## Interface
- `GATE_CYCLES`, 1000: window length in `clk_i` cycles; must be ≥ 2.
- `CNT_W`, 16: width of edge counter and `count_o`.
- `SYNC_STAGES`, 2: synchronizer depth on `sig_i`; must be ≥ 2.

Ports:
- `clk_i` input 1: reference clock; all logic is on its rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `sig_i` input 1: measured signal, asynchronous to `clk_i` (e.g. divider `clk_o`).
- `start_i` input 1: single-measurement request, sampled in IDLE only.
- `cont_i` input 1: continuous mode; level, sampled in IDLE and DONE.
- `count_o` output CNT_W: rising edges counted in the last completed window.
- `valid_o` output 1: one-cycle strobe; `count_o`/`ovf_o` updated this cycle.
- `ovf_o` output 1: last window saturated the counter.
- `busy_o` output 1: high in GATE and DONE.

## Operation
- Input path: `SYNC_STAGES` flops, then one history flop.
  - `rise = sync & ~hist`.
  - This path runs in every state, so entering GATE never creates a false edge.
- FSM states: IDLE, GATE, DONE.
- IDLE:
  - `busy_o`=0.
  - If `start_i | cont_i`, go to GATE, with `gate_cnt`←0, `edge_cnt`←0, `ovf_acc`←0.
- GATE, every cycle:
  - `gate_cnt`++.
  - If `rise`:
    - When `edge_cnt` < 2^CNT_W−1: `edge_cnt`++.
    - Otherwise hold and set `ovf_acc`.
  - In the cycle where `gate_cnt == GATE_CYCLES-1`, that cycle's rise is still counted. Then go to DONE, with `count_o`←final count and `ovf_o`←final `ovf_acc`.
- DONE (exactly one cycle):
  - `valid_o`=1. A rise in this cycle is not counted (one dead cycle).
  - If `cont_i`, go to GATE with counters cleared; otherwise go to IDLE.
- `start_i` in GATE or DONE is ignored and is not queued.
- `cont_i` dropped mid-window: the current window completes and reports normally, then the FSM goes to IDLE.
- `count_o` and `ovf_o` hold their values between strobes.
- Saturation: the counter never wraps. `count_o` = 2^CNT_W−1 whenever `ovf_o`=1.
- `gate_cnt` width is `$clog2(GATE_CYCLES)`.

## Timing
- Reset values (asynchronous, immediate):
  - `count_o`=0, `valid_o`=0, `ovf_o`=0, `busy_o`=0.
  - FSM in IDLE; sync, history and all counters 0.
- Reset mid-window: the window is aborted, there is no strobe, and outputs return to their reset values.
- Reset release with `sig_i` high: one rise pulse appears `SYNC_STAGES` cycles later. It is counted only if the FSM is in GATE.
- Edge latency: a `sig_i` rise reaches `edge_cnt` after `SYNC_STAGES`+1 clock edges.
- Start latency:
  - `start_i` sampled high at edge 0 gives GATE for cycles 1..GATE_CYCLES.
  - `valid_o` is high in cycle GATE_CYCLES+1.
- Continuous period: GATE_CYCLES+1 cycles per result.
- Input limit: `sig_i` high and low phases must each be ≥ 2 `clk_i` periods. Faster inputs give undefined counts.
- Accuracy: a signal with integer period P dividing GATE_CYCLES counts exactly GATE_CYCLES/P for any phase.

## Test plan
- **Reset:** hold `rst_i`=0 with `sig_i` toggling → `count_o`=0, `valid_o`=0, `ovf_o`=0, `busy_o`=0. Assert `rst_i` asynchronously between clock edges → outputs clear without a clock edge.
- **Single shot:** GATE_CYCLES=100, `sig_i` = divider N=10 output, one-cycle `start_i` → `busy_o` for cycles 1..101, one `valid_o` in cycle 101, `count_o`=10, `ovf_o`=0, then IDLE.
- **Continuous:** `cont_i`=1, divider N=5 → `valid_o` every 101 cycles with `count_o`=20. Drop `cont_i` mid-window → that window still reports 20, then `busy_o`=0.
- **Overflow:** CNT_W=3, GATE_CYCLES=100, period-4 `sig_i`, single shot → `count_o`=7, `ovf_o`=1. A following shot at period 20 → `count_o`=5, `ovf_o`=0.
- **Ignore and static input:** `sig_i` held at 1, start, then pulse `start_i` again in cycle 50 → exactly one `valid_o`, `count_o`=0, no second window.
- **Reset mid-window:** start with period 10, pulse `rst_i` low at cycle 40 → no `valid_o`, `count_o`=0. A new start afterwards → `count_o`=10.
